sa_a_skew_feeder: RTL
=====================

Name: sa_a_skew_feeder

Overview:
Upstream feeder for the 4x4 weight-stationary systolic array. It accepts one row of matrix A per beat, as N lanes of DW bits, over a valid/ready handshake. It applies the diagonal skew (lane k delayed by k advances) and drives the array's left-edge operand inputs and its shift enables. After the last row it injects zero rows so the skew lines and the array's partial-sum column are flushed, then pulses done.

Parameters:
N, 4, array dimension / number of lanes
DW, 16, operand width
FLUSH, 4, extra zero advances after skew drain (array depth for partial-sum exit)

Ports:
Clock  in  1  sole clock, rising edge
rst  in  1  asynchronous, active-high reset
data_clear  in  1  synchronous clear; abort to IDLE, zero all skew registers, no done
hold  in  1  array controller freeze; no advance while high
in_valid  in  1  row beat valid
in_ready  out  1  feeder can accept a beat
in_last  in  1  qualifies final row of a matrix
in_vec  in  N*DW  row; lane k = bits [k*DW +: DW]
a_left_out  out  N*DW  skewed operands to array left edge, registered
en_shift_right  out  1  array shift enable for operands, registered
en_shift_bottom  out  1  array shift enable for partial sums; identical to en_shift_right
busy  out  1  state != IDLE
done  out  1  one-cycle pulse at end of drain

Behaviour:
- Reset (async, rst=1): state IDLE; all skew registers, a_left_out, en_shift_*, done, and the drain counter = 0. in_ready = 0 while rst is high.
- in_ready = !hold && !data_clear && state != DRAIN. Accept = in_valid && in_ready at a rising edge.
- Advance = accept, or (state == DRAIN && !hold && !data_clear). Skew registers update only on an advance; otherwise they hold.
- Skew: lane 0 has 1 register stage; lane k has k+1 stages. On each advance, stage 0 of each lane loads in_vec lane k on an accept, or zero on a drain step. a_left_out lane k is the last stage of lane k. Net effect: row element k appears on a_left_out k advances after lane 0 does.
- en_shift_right/en_shift_bottom are registered copies of advance: high for exactly the cycle after each advancing edge, aligned with the new a_left_out data.
- FSM:
  - IDLE: accept with in_last -> DRAIN, cnt = N-1+FLUSH-1. Accept without in_last -> FEED.
  - FEED: accept with in_last -> DRAIN, cnt loaded as in IDLE. No beat (bubble) -> stay in FEED, no advance, array frozen.
  - DRAIN: each drain advance decrements cnt. The drain advance with cnt == 0 -> IDLE, and done is registered high for the next cycle (coincident with the last en_shift pulse).
- Total drain advances after the last row: N-1+FLUSH (7 at defaults).
- hold=1 in any state: no advance, no accept, counters frozen, outputs hold their values, en_shift_* = 0 the next cycle.
- data_clear overrides hold, accept and drain. Next edge: IDLE, skew registers zero, en_shift_* = 0, done = 0.
- Arithmetic: none on data; values pass through unmodified. cnt width = clog2(N-1+FLUSH).

Optional Feature:
SA_FEED_STALL_CNT_EN:
- Defined: adds output stall_cnt (16 bits). It counts cycles with state == FEED && !in_valid && !hold, saturates at 0xFFFF, and is cleared by rst, by data_clear, and by any IDLE->FEED/DRAIN transition.
- Undefined: the port is absent and no counter logic exists. All other behaviour is identical.

Decomposition:
- Shared package sa_pkg:
  - N and DW defaults.
  - State enum {IDLE, FEED, DRAIN}.
  - Lane-slice helper constant for width DW.
- Sub-module sa_skew_line:
  - Parameters DEPTH and DW; ports Clock, rst, clr, adv, d, q.
  - Instantiated once per lane with DEPTH = k+1.

Test Plan:
- Single row {1,2,3,4} with in_last, hold=0 -> lane0=1 in cycle C+1, lane1=2 in C+2, lane2=3 in C+3, lane3=4 in C+4; all other lane values 0. en_shift high for 8 consecutive cycles; done high only in the 8th; then busy=0.
- Four rows {r,r+1,r+2,r+3} for r=0x10,0x20,0x30,0x40, back-to-back, last on row 4 -> lane k shows row values on diagonal k; 4+7=11 consecutive en_shift pulses; exactly one done.
- Bubble: in_valid low for 3 cycles between rows 2 and 3 -> en_shift low for exactly those 3 cycles; a_left_out holds; lane output sequences are identical to the back-to-back case.
- hold raised for 2 cycles mid-DRAIN -> in_ready=0, no en_shift, cnt frozen; done is delayed by exactly 2 cycles.
- data_clear during FEED with in_valid=1 -> beat not accepted; next cycle IDLE, a_left_out=0, no done. rst pulsed mid-DRAIN -> all outputs 0 asynchronously.
- SA_FEED_STALL_CNT_EN defined: 5 bubble cycles in FEED, 2 of them under hold -> stall_cnt = 3.

Source files
------------

// File: rtl/sa_pkg.sv
// Shared defaults, state encoding and lane-slicing helper for the systolic-array
// operand feeder blocks.
package sa_pkg;

    localparam int SA_N      = 4;
    localparam int SA_DW     = 16;
    localparam int SA_LANE_W = SA_DW;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        DRAIN = 2'd2
    } sa_state_t;

    // LSB of lane k inside a packed row of dw-bit lanes.
    function automatic int lane_lsb(input int k, input int dw);
        return k * dw;
    endfunction

endpackage

// File: rtl/sa_skew_line.sv
// One lane of the diagonal skew: a DEPTH-stage shift register that only moves
// on adv, with a synchronous clear and an asynchronous reset.
module sa_skew_line
    import sa_pkg::*;
#(
    parameter int DEPTH = 1,
    parameter int DW    = SA_LANE_W
) (
    input  logic          Clock,
    input  logic          rst,
    input  logic          clr,
    input  logic          adv,
    input  logic [DW-1:0] d,
    output logic [DW-1:0] q
);

    logic [DW-1:0] stage [DEPTH];

    always_ff @(posedge Clock or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else if (clr) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else if (adv) begin
            stage[0] <= d;
            for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
    end

    assign q = stage[DEPTH-1];

endmodule

// File: rtl/sa_a_skew_feeder.sv
// Row-at-a-time operand feeder for the 4x4 weight-stationary array: skews lanes
// diagonally, drives shift enables, flushes with zero rows and pulses done.
// Optional SA_FEED_STALL_CNT_EN adds a saturating stall_cnt output.
module sa_a_skew_feeder
    import sa_pkg::*;
#(
    parameter int N     = SA_N,
    parameter int DW    = SA_DW,
    parameter int FLUSH = 4
) (
    input  logic          Clock,
    input  logic          rst,
    input  logic          data_clear,
    input  logic          hold,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_last,
    input  logic [N*DW-1:0] in_vec,
    output logic [N*DW-1:0] a_left_out,
    output logic          en_shift_right,
    output logic          en_shift_bottom,
    output logic          busy,
    output logic          done,
    output logic [1:0]    state_dbg
`ifdef SA_FEED_STALL_CNT_EN
    ,
    output logic [15:0]   stall_cnt
`endif
);

    // Handshake: a beat transfers on a rising edge where in_valid && in_ready.
    // in_ready never depends on in_valid.

    localparam int DRAIN_LEN = N - 1 + FLUSH;
    localparam int CW        = (DRAIN_LEN > 1) ? $clog2(DRAIN_LEN) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(DRAIN_LEN - 1);

    sa_state_t     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          accept, drain_adv, advance, done_d;

    assign in_ready  = !rst && !hold && !data_clear && (state_q != DRAIN);
    assign accept    = in_valid && in_ready;
    assign drain_adv = (state_q == DRAIN) && !hold && !data_clear;
    assign advance   = accept || drain_adv;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        if (data_clear) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE, FEED: begin
                    if (accept) begin
                        if (in_last) begin
                            state_d = DRAIN;
                            cnt_d   = CNT_INIT;
                        end else begin
                            state_d = FEED;
                        end
                    end
                end
                DRAIN: begin
                    if (drain_adv) begin
                        if (cnt_q == '0) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end else begin
                            cnt_d = cnt_q - 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge Clock or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            en_shift_right <= 1'b0;
            done           <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            en_shift_right <= advance;
            done           <= done_d;
        end
    end

    assign en_shift_bottom = en_shift_right;
    assign busy            = (state_q != IDLE);
    assign state_dbg       = state_q;

    // Zeros are shifted in on drain steps so every lane empties behind the last row.
    for (genvar k = 0; k < N; k++) begin : g_lane
        logic [DW-1:0] lane_d;
        assign lane_d = accept ? in_vec[lane_lsb(k, DW) +: DW] : '0;

        sa_skew_line #(
            .DEPTH (k + 1),
            .DW    (DW)
        ) u_line (
            .Clock (Clock),
            .rst   (rst),
            .clr   (data_clear),
            .adv   (advance),
            .d     (lane_d),
            .q     (a_left_out[lane_lsb(k, DW) +: DW])
        );
    end

`ifdef SA_FEED_STALL_CNT_EN
    logic start_mat;
    assign start_mat = (state_q == IDLE) && (state_d != IDLE);

    always_ff @(posedge Clock or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (data_clear || start_mat) begin
            stall_cnt <= '0;
        end else if ((state_q == FEED) && !in_valid && !hold && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule
